// File: rtl/mips_boot_loader.sv
// Boot loader: streams program/data words into the MIPS I/D-cache write ports, then raises start.
// Optional BOOT_CHECKSUM_EN adds a running sum (csum) of every word actually written.
module mips_boot_loader #(
   parameter int unsigned       DATA_W        = 32,
   parameter int unsigned       ADDR_W        = 32,
   parameter int unsigned       IMEM_DEPTH    = 256,
   parameter int unsigned       DMEM_DEPTH    = 256,
   parameter logic [ADDR_W-1:0] IBASE         = '0,
   parameter logic [ADDR_W-1:0] DBASE         = '0,
   parameter int unsigned       SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              halt,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sel,
   input  logic              s_last,
   output logic              i_we,
   output logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_data,
   output logic              d_we,
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_data,
   output logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] i_count,
   output logic [ADDR_W-1:0] d_count,
   output logic              err_ovf
`ifdef BOOT_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] csum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

   localparam int unsigned SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   state_t           state, state_nxt;
   logic [SET_W-1:0] settle_cnt;
   logic             beat, wr_ok, i_full, d_full, settle_done;
   logic             wr_i, wr_d;

   assign s_ready     = (state == S_LOAD);
   assign busy        = (state == S_LOAD) || (state == S_SETTLE);
   assign start       = (state == S_RUN);
   assign beat        = s_valid && s_ready;
   // load_req and halt both abandon the current beat; only a plain beat may write.
   assign wr_ok       = beat && !load_req && !halt;
   assign i_full      = (i_count == ADDR_W'(IMEM_DEPTH));
   assign d_full      = (d_count == ADDR_W'(DMEM_DEPTH));
   assign wr_i        = wr_ok && !s_sel && !i_full;
   assign wr_d        = wr_ok &&  s_sel && !d_full;
   // SETTLE spans SETTLE_CYCLES+1 cycles; its first cycle overlaps the final write pulse.
   assign settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      if (load_req) begin
         state_nxt = S_LOAD;
      end else begin
         case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_LOAD:   if (halt) state_nxt = S_IDLE;
                      else if (beat && s_last) state_nxt = S_SETTLE;
            S_SETTLE: if (halt) state_nxt = S_IDLE;
                      else if (settle_done) state_nxt = S_RUN;
            S_RUN:    if (halt) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle_cnt <= '0;
         i_we       <= 1'b0;
         i_addr     <= '0;
         i_data     <= '0;
         d_we       <= 1'b0;
         d_addr     <= '0;
         d_data     <= '0;
         i_count    <= '0;
         d_count    <= '0;
         err_ovf    <= 1'b0;
      end else begin
         settle_cnt <= (state == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;
         i_we       <= wr_i;
         d_we       <= wr_d;
         if (load_req) begin
            i_count <= '0;
            d_count <= '0;
            err_ovf <= 1'b0;
         end else begin
            if (wr_i) begin
               i_addr  <= IBASE + i_count;
               i_data  <= s_data;
               i_count <= i_count + ADDR_W'(1);
            end
            if (wr_d) begin
               d_addr  <= DBASE + d_count;
               d_data  <= s_data;
               d_count <= d_count + ADDR_W'(1);
            end
            if (wr_ok && (s_sel ? d_full : i_full)) err_ovf <= 1'b1;
         end
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                csum <= '0;
      else if (load_req)       csum <= '0;
      else if (wr_i || wr_d)   csum <= csum + s_data;
   end
`endif

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: table of randomized load sessions against a
// transaction-level write model, plus hand sequences for halt, restart and reset corners.
`timescale 1ns/1ps
module tb_mips_boot_loader;

   localparam int          IMEM_DEPTH = 24;
   localparam int          DMEM_DEPTH = 6;
   localparam logic [31:0] IBASE      = 32'd16;
   localparam logic [31:0] DBASE      = 32'hFFFF_FFFD;
   localparam int          SETTLE     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_req = 1'b0, halt = 1'b0, s_valid = 1'b0, s_sel = 1'b0, s_last = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready, i_we, d_we, start, busy, err_ovf;
   logic [31:0] i_addr, i_data, d_addr, d_data, i_count, d_count;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0] csum;
`endif

   mips_boot_loader #(
      .DATA_W(32), .ADDR_W(32), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH),
      .IBASE(IBASE), .DBASE(DBASE), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .halt(halt),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
      .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
      .start(start), .busy(busy), .i_count(i_count), .d_count(d_count), .err_ovf(err_ovf)
`ifdef BOOT_CHECKSUM_EN
      , .csum(csum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   // observed write pulses {addr, data}, and the writes the spec says should happen
   logic [63:0] obs_iq[$], obs_dq[$], exp_iq[$], exp_dq[$];
   always @(negedge clk) begin
      if (i_we === 1'b1) obs_iq.push_back({i_addr, i_data});
      if (d_we === 1'b1) obs_dq.push_back({d_addr, d_data});
   end

   typedef struct {
      int n_i; int n_d; bit gaps; bit mix;
      int exp_ic; int exp_dc; bit exp_ovf;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_pulse();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic send_beat(input bit sel, input logic [31:0] data, input bit last);
      s_valid = 1'b1; s_sel = sel; s_data = data; s_last = last;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic run_session(input int idx, input vec_t v);
      int ri, rd, n, ic, dc, last_cyc;
      bit ovf, sel, ready_ok, found;
      logic [31:0] data, sum_m;
      load_pulse();
      obs_iq.delete(); obs_dq.delete(); exp_iq.delete(); exp_dq.delete();
      ri = v.n_i; rd = v.n_d; n = ri + rd;
      ic = 0; dc = 0; ovf = 1'b0; ready_ok = 1'b1; sum_m = '0;
      for (int k = 0; k < n; k++) begin
         if (v.gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if (!v.mix)       sel = (rd > 0);
         else if (rd == 0) sel = 1'b0;
         else if (ri == 0) sel = 1'b1;
         else              sel = 1'($urandom_range(0, 1));
         if (sel) rd--; else ri--;
         data = $urandom;
         if (s_ready !== 1'b1) ready_ok = 1'b0;
         if (!sel) begin
            if (ic < IMEM_DEPTH) begin exp_iq.push_back({IBASE + 32'(ic), data}); ic++; sum_m += data; end
            else ovf = 1'b1;
         end else begin
            if (dc < DMEM_DEPTH) begin exp_dq.push_back({DBASE + 32'(dc), data}); dc++; sum_m += data; end
            else ovf = 1'b1;
         end
         send_beat(sel, data, k == n - 1);
      end
      last_cyc = cyc;
      check($sformatf("s%0d_ready_in_load", idx), ready_ok, 1'b1);
      check($sformatf("s%0d_busy_settle", idx), {busy, s_ready, start}, 3'b100);
      found = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (start === 1'b1) begin found = 1'b1; break; end
      end
      check($sformatf("s%0d_start_seen", idx), found, 1'b1);
      if (found) check($sformatf("s%0d_start_latency", idx), cyc - last_cyc, SETTLE + 1);
      check($sformatf("s%0d_run_flags", idx), {busy, s_ready}, 2'b00);
      check($sformatf("s%0d_i_writes", idx), obs_iq.size(), exp_iq.size());
      check($sformatf("s%0d_d_writes", idx), obs_dq.size(), exp_dq.size());
      for (int j = 0; j < exp_iq.size() && j < obs_iq.size(); j++)
         check($sformatf("s%0d_i_wr%0d", idx, j), obs_iq[j], exp_iq[j]);
      for (int j = 0; j < exp_dq.size() && j < obs_dq.size(); j++)
         check($sformatf("s%0d_d_wr%0d", idx, j), obs_dq[j], exp_dq[j]);
      check($sformatf("s%0d_i_count", idx), i_count, v.exp_ic);
      check($sformatf("s%0d_d_count", idx), d_count, v.exp_dc);
      check($sformatf("s%0d_err_ovf", idx), err_ovf, v.exp_ovf);
      check($sformatf("s%0d_model_counts", idx), {ic, dc, ovf}, {v.exp_ic, v.exp_dc, v.exp_ovf});
`ifdef BOOT_CHECKSUM_EN
      check($sformatf("s%0d_csum", idx), csum, sum_m);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      //              n_i n_d gaps mix  ic  dc ovf
      vecs[0] = '{23, 0, 1'b0, 1'b0, 23, 0, 1'b0};
      vecs[1] = '{ 3, 5, 1'b1, 1'b1,  3, 5, 1'b0};
      vecs[2] = '{26, 2, 1'b0, 1'b0, 24, 2, 1'b1};
      vecs[3] = '{ 1, 0, 1'b0, 1'b0,  1, 0, 1'b0};
      vecs[4] = '{10, 6, 1'b0, 1'b1, 10, 6, 1'b0};
      vecs[5] = '{ 4, 8, 1'b1, 1'b1,  4, 6, 1'b1};

      // reset state
      #3;
      check("rst_flags", {i_we, d_we, start, busy, s_ready, err_ovf}, 6'b0);
      check("rst_counts", {i_count, d_count}, 64'd0);
      check("rst_i_bus", {i_addr, i_data}, 64'd0);
      check("rst_d_bus", {d_addr, d_data}, 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // IDLE ignores stream traffic
      obs_iq.delete(); obs_dq.delete();
      s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1 s_valid = 1'b0;
      check("idle_no_accept", {s_ready, i_count, obs_iq.size() > 0}, 34'd0);

      for (int s = 0; s < 6; s++) run_session(s, vecs[s]);

      // halt in RUN: start drops next cycle, counters hold; then restart clears
      halt = 1'b1; @(posedge clk); #1; halt = 1'b0;
      check("halt_run_flags", {start, busy, s_ready}, 3'b000);
      check("halt_run_keep", {i_count, d_count, err_ovf}, {32'd4, 32'd6, 1'b1});
      load_pulse();
      check("restart_clear", {i_count, d_count, err_ovf}, 65'd0);
      check("restart_load", {busy, s_ready, start}, 3'b110);

      // halt during LOAD keeps counters and stays idle
      send_beat(1'b0, 32'h1111, 1'b0);
      send_beat(1'b0, 32'h2222, 1'b0);
      halt = 1'b1; @(posedge clk); #1; halt = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("halt_load", {busy, s_ready, start, i_count}, {3'b000, 32'd2});

      // load_req during SETTLE (with simultaneous halt) restarts the session
      load_pulse();
      send_beat(1'b0, 32'h3333, 1'b1);
      check("settle_state", {busy, s_ready}, 2'b10);
      load_req = 1'b1; halt = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0; halt = 1'b0;
      check("reload_in_settle", {busy, s_ready, start, i_count}, {3'b110, 32'd0});

`ifdef BOOT_CHECKSUM_EN
      send_beat(1'b1, 32'd42, 1'b0);
      send_beat(1'b1, 32'd23, 1'b0);
      send_beat(1'b1, 32'd16, 1'b0);
      send_beat(1'b1, 32'd8, 1'b0);
      send_beat(1'b1, 32'd156, 1'b1);
      check("csum_245", {csum, d_count}, {32'd245, 32'd5});
      load_pulse();
`endif

      // reset in the middle of a live write pulse
      send_beat(1'b0, 32'd42, 1'b0);
      send_beat(1'b0, 32'd23, 1'b0);
      send_beat(1'b0, 32'd16, 1'b0);
      check("pre_rst_write", {i_we, i_count, i_addr, i_data}, {1'b1, 32'd3, IBASE + 32'd2, 32'd16});
      rst = 1'b0;
      #1;
      check("mid_rst_flags", {i_we, d_we, start, busy, s_ready, err_ovf}, 6'b0);
      check("mid_rst_bus", {i_addr, i_data, i_count, d_count}, 128'd0);
`ifdef BOOT_CHECKSUM_EN
      check("mid_rst_csum", csum, 32'd0);
`endif
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
